// File: rtl/mod_n_cascade_timer.sv
// mod_n_cascade_timer
// Chain of DIGITS down-counting digits. Each digit has its own modulus, so the
// chain can count down an MM:SS (or any mixed-radix) preset.
// A small control FSM (IDLE/RUN/PAUSED/DONE) decides when a tick decrements the
// chain. It also latches completion until software acknowledges it with start.
module mod_n_cascade_timer #(
  parameter int                    DIGITS = 4,
  parameter int                    W      = 4,
  parameter logic [DIGITS*W-1:0]   MODS   = 16'hAA6A
) (
  input  logic                clk,
  input  logic                clrn,
  input  logic                loadn,
  input  logic [DIGITS*W-1:0] data,
  input  logic                start,
  input  logic                pause,
  input  logic                cancel,
  input  logic                tick,
  output logic [DIGITS*W-1:0] out,
  output logic                tc,
  output logic                zero,
  output logic                running,
  output logic                done,
  output logic [1:0]          state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Largest legal value of each digit (modulus - 1).
  // A modulus field of 0 encodes 2^W, and subtracting 1 in W bits then gives all
  // ones, which is the correct maximum for that case.
  function automatic logic [DIGITS*W-1:0] max_values();
    logic [DIGITS*W-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[W*i +: W] = MODS[W*i +: W] - W'(1);
    end
    return r;
  endfunction

  localparam logic [DIGITS*W-1:0] MAXV = max_values();

  state_t              state_q, state_d;
  logic [DIGITS*W-1:0] out_q, out_d;
  logic                zero_q, zero_d;
  logic                running_q, running_d;
  logic                done_q, done_d;

  logic [DIGITS*W-1:0] clamped;
  logic [DIGITS*W-1:0] dec_val;
  logic [DIGITS:0]     borrow;
  logic                last_count;

  // Preset value with each digit clamped to its own modulus minus one.
  // Example: loading 0xC into a mod-10 digit gives 9.
  always_comb begin
    clamped = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (data[W*i +: W] > MAXV[W*i +: W]) begin
        clamped[W*i +: W] = MAXV[W*i +: W];
      end else begin
        clamped[W*i +: W] = data[W*i +: W];
      end
    end
  end

  // Borrow ripples from digit 0 upward.
  // A digit that receives a borrow and is already zero wraps to its maximum and
  // passes the borrow on to the next digit.
  always_comb begin
    dec_val   = out_q;
    borrow    = '0;
    borrow[0] = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow[i]) begin
        if (out_q[W*i +: W] == '0) begin
          dec_val[W*i +: W] = MAXV[W*i +: W];
          borrow[i+1]       = 1'b1;
        end else begin
          dec_val[W*i +: W] = out_q[W*i +: W] - W'(1);
          borrow[i+1]       = 1'b0;
        end
      end else begin
        dec_val[W*i +: W] = out_q[W*i +: W];
        borrow[i+1]       = 1'b0;
      end
    end
  end

  // Terminal count: the next accepted tick takes the whole chain from 1 to 0.
  always_comb begin
    last_count = (out_q == (DIGITS*W)'(1));
    tc         = (state_q == RUN) && tick && !pause && last_count;
  end

  // Next count and next state.
  // Priority, highest first: cancel, then load, then the FSM.
  // The status flags are derived from the next values so that they change on
  // the same edge as the count and the state.
  always_comb begin
    out_d   = out_q;
    state_d = state_q;
    if (cancel) begin
      out_d   = '0;
      state_d = IDLE;
    end else if (!loadn) begin
      out_d   = clamped;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !pause && !zero_q) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (pause) begin
            state_d = PAUSED;
          end else if (tick) begin
            if (last_count) begin
              out_d   = '0;
              state_d = DONE;
            end else begin
              out_d = dec_val;
            end
          end
        end
        PAUSED: begin
          if (start && !pause) begin
            state_d = RUN;
          end
        end
        DONE: begin
          out_d = '0;
          if (start) begin
            state_d = IDLE;
          end
        end
        default: begin
          out_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
    zero_d    = (out_d == '0);
    running_d = (state_d == RUN);
    done_d    = (state_d == DONE);
  end

  // Count, state and registered status flags, with asynchronous active-low clear.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      out_q     <= '0;
      state_q   <= IDLE;
      zero_q    <= 1'b1;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      out_q     <= out_d;
      state_q   <= state_d;
      zero_q    <= zero_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign out     = out_q;
  assign zero    = zero_q;
  assign running = running_q;
  assign done    = done_q;
  assign state   = state_q;

endmodule

// File: tb/tb_mod_n_cascade_timer.sv
// tb_mod_n_cascade_timer
// Directed scoreboard bench for the default MM:SS timer (moduli 10,6,10,10).
// The stimulus process pushes hand-computed expectations into a queue.
// The monitor process pops each entry and checks it:
//   - tc just before the active edge,
//   - the registered outputs just after the active edge.
module tb_mod_n_cascade_timer;

  logic        clk;
  logic        clrn;
  logic        loadn;
  logic [15:0] data;
  logic        start;
  logic        pause;
  logic        cancel;
  logic        tick;
  logic [15:0] out;
  logic        tc;
  logic        zero;
  logic        running;
  logic        done;
  logic [1:0]  state;

  typedef struct {
    bit          chk_tc;
    bit          tc_exp;
    bit          chk_regs;
    logic [15:0] out_exp;
    logic        zero_exp;
    logic        running_exp;
    logic        done_exp;
    logic [1:0]  state_exp;
  } item_t;

  item_t sb[$];
  string sb_names[$];

  int check_count = 0;
  int pass_count  = 0;

  mod_n_cascade_timer #(
    .DIGITS (4),
    .W      (4),
    .MODS   (16'hAA6A)
  ) dut (
    .clk     (clk),
    .clrn    (clrn),
    .loadn   (loadn),
    .data    (data),
    .start   (start),
    .pause   (pause),
    .cancel  (cancel),
    .tick    (tick),
    .out     (out),
    .tc      (tc),
    .zero    (zero),
    .running (running),
    .done    (done),
    .state   (state)
  );

  // 10-unit clock period; inputs change on the falling edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one cycle of inputs, aligned to the falling edge.
  task automatic applyStimulus(input logic ld_n, input logic [15:0] d, input logic st,
                               input logic ps, input logic cn, input logic tk);
    @(negedge clk);
    loadn  = ld_n;
    data   = d;
    start  = st;
    pause  = ps;
    cancel = cn;
    tick   = tk;
  endtask

  // Queue the expectation for the cycle just driven.
  // zero, running and done follow from the expected count and state.
  task automatic checkOutput(input string name, input bit chk_tc, input bit tc_exp,
                             input bit chk_regs, input logic [15:0] out_exp,
                             input logic [1:0] state_exp);
    item_t it;
    it.chk_tc      = chk_tc;
    it.tc_exp      = tc_exp;
    it.chk_regs    = chk_regs;
    it.out_exp     = out_exp;
    it.zero_exp    = (out_exp == 16'h0000);
    it.running_exp = (state_exp == 2'd1);
    it.done_exp    = (state_exp == 2'd3);
    it.state_exp   = state_exp;
    sb.push_back(it);
    sb_names.push_back(name);
  endtask

  task automatic compare(input string what, input logic [15:0] act, input logic [15:0] exp);
    check_count++;
    if (act === exp) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got %h expected %h", what, act, exp);
    end
  endtask

  // Monitor: pop one expectation per cycle when one is pending.
  // tc is checked before the rising edge; registered outputs are checked after it.
  initial begin
    item_t it;
    string nm;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() != 0) begin
        it = sb.pop_front();
        nm = sb_names.pop_front();
        if (it.chk_tc) compare({nm, ".tc"}, 16'(tc), 16'(it.tc_exp));
        @(posedge clk);
        #1;
        if (it.chk_regs) begin
          compare({nm, ".out"}, out, it.out_exp);
          compare({nm, ".zero"}, 16'(zero), 16'(it.zero_exp));
          compare({nm, ".running"}, 16'(running), 16'(it.running_exp));
          compare({nm, ".done"}, 16'(done), 16'(it.done_exp));
          compare({nm, ".state"}, 16'(state), 16'(it.state_exp));
        end
      end
    end
  end

  initial begin
    clrn   = 1'b0;
    loadn  = 1'b1;
    data   = 16'h0000;
    start  = 1'b0;
    pause  = 1'b0;
    cancel = 1'b0;
    tick   = 1'b0;

    // Reset values while clrn is held low.
    applyStimulus(1, 16'h0000, 0, 0, 0, 0);
    checkOutput("reset", 1, 0, 1, 16'h0000, 2'd0);
    @(posedge clk);
    #3 clrn = 1'b1;

    // 01:30 minus 31 ticks is 00:59; tc must stay low on every tick.
    applyStimulus(0, 16'h0130, 0, 0, 0, 0);
    checkOutput("load_0130", 0, 0, 1, 16'h0130, 2'd0);
    applyStimulus(1, 16'h0000, 1, 0, 0, 0);
    checkOutput("start_0130", 0, 0, 1, 16'h0130, 2'd1);
    for (int i = 0; i < 31; i++) begin
      applyStimulus(1, 16'h0000, 0, 0, 0, 1);
      checkOutput("tick31", 1, 0, (i == 30), 16'h0059, 2'd1);
    end

    // Terminal count, latched done, ticks ignored in DONE, then acknowledge.
    applyStimulus(0, 16'h0002, 0, 0, 0, 0);
    checkOutput("load_0002", 0, 0, 1, 16'h0002, 2'd0);
    applyStimulus(1, 16'h0000, 1, 0, 0, 0);
    checkOutput("start_0002", 0, 0, 1, 16'h0002, 2'd1);
    applyStimulus(1, 16'h0000, 0, 0, 0, 1);
    checkOutput("tick_to_1", 1, 0, 1, 16'h0001, 2'd1);
    applyStimulus(1, 16'h0000, 0, 0, 0, 1);
    checkOutput("tick_terminal", 1, 1, 1, 16'h0000, 2'd3);
    applyStimulus(1, 16'h0000, 0, 0, 0, 0);
    checkOutput("done_hold", 1, 0, 1, 16'h0000, 2'd3);
    applyStimulus(1, 16'h0000, 0, 0, 0, 1);
    checkOutput("done_tick_ignored", 1, 0, 1, 16'h0000, 2'd3);
    applyStimulus(1, 16'h0000, 1, 0, 0, 0);
    checkOutput("done_ack", 0, 0, 1, 16'h0000, 2'd0);

    // A tick in the same cycle as start is not counted.
    // Then 10:00 minus one tick borrows all the way to 09:59.
    applyStimulus(0, 16'h1000, 0, 0, 0, 0);
    checkOutput("load_1000", 0, 0, 1, 16'h1000, 2'd0);
    applyStimulus(1, 16'h0000, 1, 0, 0, 1);
    checkOutput("start_with_tick", 1, 0, 1, 16'h1000, 2'd1);
    applyStimulus(1, 16'h0000, 0, 0, 0, 1);
    checkOutput("full_borrow", 1, 0, 1, 16'h0959, 2'd1);

    // Pause wins over tick; ticks are ignored while paused; resume keeps the count.
    applyStimulus(0, 16'h0010, 0, 0, 0, 0);
    checkOutput("load_0010", 0, 0, 1, 16'h0010, 2'd0);
    applyStimulus(1, 16'h0000, 1, 0, 0, 0);
    checkOutput("start_0010", 0, 0, 1, 16'h0010, 2'd1);
    applyStimulus(1, 16'h0000, 0, 1, 0, 1);
    checkOutput("pause_and_tick", 1, 0, 1, 16'h0010, 2'd2);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 16'h0000, 0, 0, 0, 1);
      checkOutput("paused_tick", 1, 0, (i == 4), 16'h0010, 2'd2);
    end
    applyStimulus(1, 16'h0000, 1, 0, 0, 0);
    checkOutput("resume", 0, 0, 1, 16'h0010, 2'd1);
    applyStimulus(1, 16'h0000, 0, 0, 0, 1);
    checkOutput("resume_tick", 1, 0, 1, 16'h0009, 2'd1);

    // Per-digit clamping; starting from zero is refused and done stays low.
    applyStimulus(0, 16'hFF7C, 0, 0, 0, 0);
    checkOutput("clamp", 0, 0, 1, 16'h9959, 2'd0);
    applyStimulus(0, 16'h0000, 0, 0, 0, 0);
    checkOutput("load_zero", 0, 0, 1, 16'h0000, 2'd0);
    applyStimulus(1, 16'h0000, 1, 0, 0, 0);
    checkOutput("start_on_zero", 0, 0, 1, 16'h0000, 2'd0);

    // Load wins over start and tick in the same cycle.
    applyStimulus(0, 16'h0005, 1, 0, 0, 1);
    checkOutput("load_over_start", 0, 0, 1, 16'h0005, 2'd0);

    // Cancel wins over load while running.
    applyStimulus(1, 16'h0000, 1, 0, 0, 0);
    checkOutput("start_0005", 0, 0, 1, 16'h0005, 2'd1);
    applyStimulus(0, 16'h1234, 0, 0, 1, 0);
    checkOutput("cancel_over_load", 0, 0, 1, 16'h0000, 2'd0);

    // A short clrn pulse that lands entirely between rising edges must still
    // clear the running timer.
    applyStimulus(0, 16'h0130, 0, 0, 0, 0);
    checkOutput("reload_0130", 0, 0, 1, 16'h0130, 2'd0);
    applyStimulus(1, 16'h0000, 1, 0, 0, 0);
    checkOutput("restart_0130", 0, 0, 1, 16'h0130, 2'd1);
    applyStimulus(1, 16'h0000, 0, 0, 0, 1);
    checkOutput("tick_0129", 1, 0, 1, 16'h0129, 2'd1);
    applyStimulus(1, 16'h0000, 0, 0, 0, 0);
    clrn = 1'b0;
    checkOutput("clrn_async", 1, 0, 1, 16'h0000, 2'd0);
    #3 clrn = 1'b1;
    applyStimulus(1, 16'h0000, 1, 0, 0, 0);
    checkOutput("start_after_clrn", 0, 0, 1, 16'h0000, 2'd0);

    // Let the monitor drain the queue, with a bounded wait.
    for (int i = 0; i < 10 && sb.size() != 0; i++) begin
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    if (sb.size() != 0) begin
      check_count++;
      $display("[TB] FAIL drain: got %0d pending expectations required 0", sb.size());
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
